// File: rtl/ppm_rx_frontend.sv
// PPM receive front end: synchronises and deglitches the raw pulse line, strobes accepted
// rising edges, measures pulse spacing and reports idle / stuck-high / glitch statistics.
module ppm_rx_frontend #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_CT   = 16,
   parameter int unsigned IDLE_CT     = 60000,
   parameter int unsigned STUCK_CT    = 15000,
   parameter int unsigned IW          = 20
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pulse_in,
   input  logic          clear_stats,
   output logic          pulse_out,
   output logic          level_out,
   output logic [IW-1:0] interval,
   output logic          interval_valid,
   output logic          idle,
   output logic          stuck,
   output logic [7:0]    glitch_ct
);

   localparam int unsigned FW = (FILTER_CT > 1) ? $clog2(FILTER_CT) : 1;
   localparam int unsigned DW = (IDLE_CT > 1) ? $clog2(IDLE_CT) : 1;
   localparam int unsigned SW = (STUCK_CT > 1) ? $clog2(STUCK_CT) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [FW-1:0]          fc_q, fc_d;
   logic                   level_q, level_d;
   logic                   pulse_q;
   logic                   rise, glitch;
   logic [7:0]             glitch_q, glitch_d;
   logic [IW-1:0]          ic_q, ic_d;
   logic [IW-1:0]          interval_q, interval_d;
   logic                   valid_q, valid_d;
   logic                   first_q, first_d;
   logic [DW-1:0]          idc_q, idc_d;
   logic                   idle_q, idle_d;
   logic                   idle_set;
   logic [SW-1:0]          sc_q, sc_d;
   logic                   stuck_q, stuck_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      fc_d    = '0;
      level_d = level_q;
      rise    = 1'b0;
      glitch  = 1'b0;
      if (s != level_q) begin
         if (fc_q == FW'(FILTER_CT - 1)) begin
            level_d = ~level_q;
            rise    = ~level_q;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end else if (!level_q && (fc_q != '0)) begin
         // High run collapsed before acceptance; low-going runs are not counted.
         glitch = 1'b1;
      end
   end

   always_comb begin
      glitch_d = glitch_q;
      if (clear_stats) begin
         glitch_d = '0;
      end else if (glitch && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   // A rise in the same cycle the idle count expires holds idle off.
   assign idle_set = !idle_q && !pulse_q && !rise && (idc_q == DW'(IDLE_CT - 1));

   always_comb begin
      ic_d       = rise ? IW'(1) : ((&ic_q) ? ic_q : ic_q + 1'b1);
      valid_d    = rise && first_q;
      interval_d = (rise && first_q) ? ic_q : interval_q;
      first_d    = first_q;
      if (rise) begin
         first_d = 1'b1;
      end else if (idle_set) begin
         first_d = 1'b0;
      end
   end

   always_comb begin
      idc_d  = idc_q;
      idle_d = idle_q;
      if (pulse_q) begin
         idc_d  = '0;
         idle_d = 1'b0;
      end else if (idle_set) begin
         idle_d = 1'b1;
      end else if (!idle_q && (idc_q != DW'(IDLE_CT - 1))) begin
         idc_d = idc_q + 1'b1;
      end
   end

   always_comb begin
      sc_d    = sc_q;
      stuck_d = stuck_q;
      if (!level_q) begin
         sc_d    = '0;
         stuck_d = 1'b0;
      end else if (!stuck_q) begin
         if (sc_q == SW'(STUCK_CT - 1)) begin
            stuck_d = 1'b1;
         end else begin
            sc_d = sc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         fc_q       <= '0;
         level_q    <= 1'b0;
         pulse_q    <= 1'b0;
         glitch_q   <= '0;
         ic_q       <= '0;
         interval_q <= '0;
         valid_q    <= 1'b0;
         first_q    <= 1'b0;
         idc_q      <= '0;
         idle_q     <= 1'b1;
         sc_q       <= '0;
         stuck_q    <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], pulse_in};
         fc_q       <= fc_d;
         level_q    <= level_d;
         pulse_q    <= rise;
         glitch_q   <= glitch_d;
         ic_q       <= ic_d;
         interval_q <= interval_d;
         valid_q    <= valid_d;
         first_q    <= first_d;
         idc_q      <= idc_d;
         idle_q     <= idle_d;
         sc_q       <= sc_d;
         stuck_q    <= stuck_d;
      end
   end

   assign pulse_out      = pulse_q;
   assign level_out      = level_q;
   assign interval       = interval_q;
   assign interval_valid = valid_q;
   assign idle           = idle_q;
   // Masked by level so stuck drops in the same cycle the line falls.
   assign stuck          = stuck_q & level_q;
   assign glitch_ct      = glitch_q;

endmodule

// File: doc/ppm_rx_frontend.md
Name: ppm_rx_frontend

Overview:
- Conditions the raw PPM pulse line arriving from the remote node (GPIO input pin) before it reaches the Decoder.
- Synchronises the asynchronous pin into clk and rejects glitches shorter than a programmable width.
- Emits a single-cycle strobe per accepted pulse and measures the spacing between pulses.
- Reports link health: idle, stuck-high, and a saturating glitch count. Sits between the GPIO pin and the Decoder's pulse input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range ≥2).
- FILTER_CT, 16, consecutive synchronised cycles of a new level required before the filtered level changes (≥1).
- IDLE_CT, 60000, cycles without an accepted rising edge before idle asserts.
- STUCK_CT, 15000, cycles of continuous filtered-high before stuck asserts.
- IW, 20, width of the interval output.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- pulse_in, input, 1, raw asynchronous pulse line from the pin.
- clear_stats, input, 1, synchronous clear of glitch_ct.
- pulse_out, output, 1, one-cycle strobe on each accepted rising edge; drives the Decoder pulse input.
- level_out, output, 1, filtered line level.
- interval, output, IW, cycles between the two most recent accepted rising edges.
- interval_valid, output, 1, one-cycle strobe when interval updates.
- idle, output, 1, no accepted edge for IDLE_CT cycles.
- stuck, output, 1, level_out high for ≥STUCK_CT cycles.
- glitch_ct, output, 8, saturating count of rejected high runs.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). Every flop clears asynchronously on rst_n low, including the synchroniser chain, filter counter, level_out, interval counter, interval, glitch_ct and the first-edge flag.
- Output values during and after reset: pulse_out=0, level_out=0, interval=0, interval_valid=0, stuck=0, glitch_ct=0, idle=1.
- Synchroniser: s = output of the SYNC_STAGES flop chain.
- Filter counter fc:
  - If s == level_out, fc <= 0.
  - Otherwise fc increments.
  - When fc reaches FILTER_CT-1 while s != level_out, level_out toggles on that edge and fc <= 0.
  - Net effect: level_out follows s exactly FILTER_CT cycles after s settles.
- Latency: raw rise sampled at edge 0 → s high after SYNC_STAGES edges → level_out and pulse_out high FILTER_CT edges later. Total SYNC_STAGES+FILTER_CT cycles.
- pulse_out: high exactly in the cycle where level_out goes 0→1; never on the falling edge.
- Glitch:
  - While level_out=0, a run of s=1 that returns to 0 before acceptance (fc>0 and s==0) increments glitch_ct.
  - glitch_ct saturates at 255.
  - clear_stats forces glitch_ct to 0 and wins over a simultaneous increment.
  - Low-going glitches while level_out=1 are filtered but not counted.
- Interval counter ic (IW bits):
  - On a pulse_out cycle, ic <= 1; otherwise ic <= ic+1, saturating at all-ones.
  - On a pulse_out cycle with the first-edge flag set, interval <= ic and interval_valid=1 for that cycle. The result is cycles elapsed since the previous pulse_out (e.g. consecutive pulses 100 cycles apart give 100). A saturated ic reports all-ones and still strobes valid.
  - The first accepted edge after reset, or after idle asserts, only sets the first-edge flag and does not strobe interval_valid.
- Idle:
  - A separate idle counter restarts on pulse_out.
  - idle deasserts in the cycle after pulse_out.
  - idle asserts when IDLE_CT cycles elapse after the last pulse_out. Asserting idle clears the first-edge flag.
- Stuck:
  - A counter runs while level_out=1; stuck asserts when it reaches STUCK_CT.
  - stuck clears in the cycle level_out falls.
  - No pulse_out is generated until the line falls and rises again.
- Simultaneous events: a pulse_out in the same cycle the idle count expires means the pulse wins, so idle stays 0.
- Mid-operation reset: all state clears immediately. A pulse already in flight on pulse_in is re-filtered from scratch after release.

Test Plan (sim params SYNC_STAGES=2, FILTER_CT=4, IDLE_CT=100, STUCK_CT=50, IW=16):
- Reset: assert rst_n=0 mid-run → idle=1, glitch_ct=0, pulse_out=0, level_out=0 asynchronously; all hold for 10 cycles after release with pulse_in=0.
- Clean pulse: pulse_in high 10 cycles → pulse_out one cycle, 6 cycles after the rise is first sampled; level_out high for 10 cycles; glitch_ct unchanged.
- Glitch: pulse_in high 2 cycles, then 3 cycles → no pulse_out, glitch_ct=2. Then clear_stats pulsed coincident with a third 2-cycle glitch's rejection → glitch_ct=0.
- Interval: three 10-cycle pulses with rises 40 cycles apart → no interval_valid on the first, then two interval_valid strobes each with interval=40; idle=0 throughout.
- Idle/stuck:
  - No pulses for 100 cycles after the last pulse_out → idle=1; the next pulse produces no interval_valid.
  - pulse_in held high 80 cycles → stuck=1 at 50 cycles after level_out rises, clears on the fall.
- Saturation: 300 glitches → glitch_ct=255. Pulses 70000 cycles apart with IDLE_CT raised to 100000 → interval=16'hFFFF with interval_valid.
